// File: rtl/rgb_matrix_scan.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_matrix_scan
//  Purpose  : Row/column scan controller for a 16x16 RGB LED panel. Shifts one
//             row of R/G/B bits, latches it, then displays it with OE_N low.
//  Revision : 1.0 - initial release
// ============================================================================
module rgb_matrix_scan #(
  parameter int CLK_DIV      = 1,
  parameter int BLANK_CYCLES = 2,
  parameter int ON_CYCLES    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_r_in,
  input  logic       i_g_in,
  input  logic       i_b_in,
  output logic [3:0] o_col_sel,
  output logic [3:0] o_row_sel,
  output logic [3:0] o_row_addr,
  output logic       o_r_out,
  output logic       o_g_out,
  output logic       o_b_out,
  output logic       o_sclk,
  output logic       o_latch,
  output logic       o_oe_n,
  output logic       o_frame_done
);

  localparam logic [15:0] c_DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] c_BLANK_LAST = 16'(BLANK_CYCLES - 1);
  localparam logic [15:0] c_ON_LAST    = 16'(ON_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_BLANK   = 3'd2,
    S_LATCH   = 3'd3,
    S_DISPLAY = 3'd4
  } state_t;

  state_t      r_state, w_state;
  logic [15:0] r_cnt,   w_cnt;
  logic        r_phase, w_phase;
  logic [3:0]  r_col,   w_col;
  logic [3:0]  r_row,   w_row;
  logic [3:0]  r_addr,  w_addr;
  logic        r_r,     w_r;
  logic        r_g,     w_g;
  logic        r_b,     w_b;
  logic        r_sclk,  w_sclk;
  logic        r_latch, w_latch;
  logic        r_oe_n,  w_oe_n;
  logic        r_done,  w_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_col   <= '0;
      r_row   <= '0;
      r_addr  <= '0;
      r_r     <= 1'b0;
      r_g     <= 1'b0;
      r_b     <= 1'b0;
      r_sclk  <= 1'b0;
      r_latch <= 1'b0;
      r_oe_n  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_phase <= w_phase;
      r_col   <= w_col;
      r_row   <= w_row;
      r_addr  <= w_addr;
      r_r     <= w_r;
      r_g     <= w_g;
      r_b     <= w_b;
      r_sclk  <= w_sclk;
      r_latch <= w_latch;
      r_oe_n  <= w_oe_n;
      r_done  <= w_done;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_phase = r_phase;
    w_col   = r_col;
    w_row   = r_row;
    w_addr  = r_addr;
    w_r     = r_r;
    w_g     = r_g;
    w_b     = r_b;
    w_sclk  = r_sclk;
    w_latch = 1'b0;
    w_oe_n  = r_oe_n;
    w_done  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_oe_n = 1'b1;
        w_sclk = 1'b0;
        if (i_en) begin
          w_state = S_SHIFT;
          w_cnt   = '0;
          w_phase = 1'b0;
          w_r     = i_r_in;
          w_g     = i_g_in;
          w_b     = i_b_in;
        end
      end

      S_SHIFT: begin
        if (r_cnt == c_DIV_LAST) begin
          w_cnt = '0;
          if (!r_phase) begin
            w_sclk  = 1'b1;
            w_col   = r_col + 4'd1;
            w_phase = 1'b1;
          end else begin
            w_sclk  = 1'b0;
            w_phase = 1'b0;
            // Column select has already wrapped to 0 after column 15's rise.
            if (r_col == 4'd0) begin
              w_state = S_BLANK;
            end else begin
              w_r = i_r_in;
              w_g = i_g_in;
              w_b = i_b_in;
            end
          end
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end

      S_BLANK: begin
        if (r_cnt == c_BLANK_LAST) begin
          w_cnt   = '0;
          w_state = S_LATCH;
          w_latch = 1'b1;
          w_addr  = r_row;
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end

      S_LATCH: begin
        w_state = S_DISPLAY;
        w_oe_n  = 1'b0;
        w_cnt   = '0;
      end

      S_DISPLAY: begin
        if (r_cnt == c_ON_LAST) begin
          w_cnt  = '0;
          w_oe_n = 1'b1;
          w_row  = r_row + 4'd1;
          w_done = (r_row == 4'd15);
          if (i_en) begin
            w_state = S_SHIFT;
            w_phase = 1'b0;
            w_r     = i_r_in;
            w_g     = i_g_in;
            w_b     = i_b_in;
          end else begin
            w_state = S_IDLE;
          end
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end

      default: begin
        w_state = S_IDLE;
        w_oe_n  = 1'b1;
        w_sclk  = 1'b0;
      end
    endcase
  end

  assign o_col_sel    = r_col;
  assign o_row_sel    = r_row;
  assign o_row_addr   = r_addr;
  assign o_r_out      = r_r;
  assign o_g_out      = r_g;
  assign o_b_out      = r_b;
  assign o_sclk       = r_sclk;
  assign o_latch      = r_latch;
  assign o_oe_n       = r_oe_n;
  assign o_frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rgb_matrix_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rgb_matrix_scan
//  Purpose  : Scoreboard bench for rgb_matrix_scan (default and CLK_DIV=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_matrix_scan;

  typedef struct {
    int addr;
    int cyc;
  } lat_t;

  logic clk = 1'b0;
  logic rst;
  logic en, en2;

  logic [3:0] col_sel, row_sel, row_addr;
  logic       r_out, g_out, b_out, sclk, latch, oe_n, fd;
  logic       r_in, g_in, b_in;

  logic [3:0] col_sel2, row_sel2, row_addr2;
  logic       r_out2, g_out2, b_out2, sclk2, latch2, oe_n2, fd2;
  logic       r_in2, g_in2, b_in2;

  logic [15:0] pr [16];
  logic [15:0] pg [16];
  logic [15:0] pb [16];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int viol  = 0;
  int n0;
  bit mon_data = 0, mon_data2 = 0, rst_pulsed = 0;

  logic [2:0] q_data  [$];
  logic [2:0] q_data2 [$];
  lat_t       q_lat   [$];
  lat_t       q_lat2  [$];
  int         q_fd    [$];

  always #5 clk = ~clk;

  assign r_in  = pr[row_sel][col_sel];
  assign g_in  = pg[row_sel][col_sel];
  assign b_in  = pb[row_sel][col_sel];
  assign r_in2 = pr[row_sel2][col_sel2];
  assign g_in2 = pg[row_sel2][col_sel2];
  assign b_in2 = pb[row_sel2][col_sel2];

  rgb_matrix_scan dut (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_r_in(r_in), .i_g_in(g_in), .i_b_in(b_in),
    .o_col_sel(col_sel), .o_row_sel(row_sel), .o_row_addr(row_addr),
    .o_r_out(r_out), .o_g_out(g_out), .o_b_out(b_out),
    .o_sclk(sclk), .o_latch(latch), .o_oe_n(oe_n), .o_frame_done(fd)
  );

  rgb_matrix_scan #(.CLK_DIV(3), .BLANK_CYCLES(2), .ON_CYCLES(4)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_en(en2),
    .i_r_in(r_in2), .i_g_in(g_in2), .i_b_in(b_in2),
    .o_col_sel(col_sel2), .o_row_sel(row_sel2), .o_row_addr(row_addr2),
    .o_r_out(r_out2), .o_g_out(g_out2), .o_b_out(b_out2),
    .o_sclk(sclk2), .o_latch(latch2), .o_oe_n(oe_n2), .o_frame_done(fd2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_row_data(input int row, input bit second);
    for (int k = 0; k < 16; k++) begin
      if (second) q_data2.push_back({pr[row][k], pg[row][k], pb[row][k]});
      else        q_data.push_back({pr[row][k], pg[row][k], pb[row][k]});
    end
  endtask

  task automatic push_rows(input int base, input int nrows);
    for (int r = 0; r < nrows; r++) q_lat.push_back('{r % 16, base + 34 + 39 * r});
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor for the default-parameter instance.
  initial begin : mon1
    logic [2:0] d, pd, e;
    logic ps, pl, po;
    int   olow;
    lat_t le;
    pd = 3'b0; ps = 1'b0; pl = 1'b0; po = 1'b1; olow = 0;
    forever begin
      @(negedge clk);
      d = {r_out, g_out, b_out};
      if (sclk && !ps && mon_data) begin
        if (q_data.size() == 0) check("sclk_unexpected", 1, 0);
        else begin
          e = q_data.pop_front();
          check("rgb_at_sclk_rise", d, e);
        end
      end
      if (d !== pd && sclk) viol++;
      if (sclk && latch) viol++;
      if (!oe_n && (sclk || latch)) viol++;
      if (!oe_n && po && !pl) viol++;
      if (latch) begin
        if (q_lat.size() == 0) check("latch_unexpected", 1, 0);
        else begin
          le = q_lat.pop_front();
          check("latch_cycle", cyc, le.cyc);
          check("row_addr_at_latch", row_addr, le.addr);
          check("row_sel_at_latch", row_sel, le.addr);
        end
      end
      if (rst_pulsed) begin
        rst_pulsed = 0;
        olow = 0;
      end else if (!oe_n) begin
        olow++;
      end else if (!po) begin
        check("oe_low_len", olow, 4);
        olow = 0;
      end
      if (fd) begin
        if (q_fd.size() == 0) check("frame_done_unexpected", 1, 0);
        else check("frame_done_cycle", cyc, q_fd.pop_front());
      end
      pd = d; ps = sclk; pl = latch; po = oe_n;
    end
  end

  // Monitor for the CLK_DIV=3 instance.
  initial begin : mon2
    logic [2:0] d, pd, e;
    logic ps, po;
    int   hi, lo, rises, olow;
    lat_t le;
    pd = 3'b0; ps = 1'b0; po = 1'b1; hi = 0; lo = 0; rises = 0; olow = 0;
    forever begin
      @(negedge clk);
      d = {r_out2, g_out2, b_out2};
      if (sclk2 && !ps) begin
        if (rises > 0) check("div3_sclk_low_len", lo, 3);
        lo = 0;
        rises++;
        if (mon_data2) begin
          if (q_data2.size() == 0) check("div3_sclk_unexpected", 1, 0);
          else begin
            e = q_data2.pop_front();
            check("div3_rgb_at_rise", d, e);
          end
        end
      end
      if (!sclk2 && ps) begin
        check("div3_sclk_high_len", hi, 3);
        hi = 0;
      end
      if (sclk2) hi++; else lo++;
      if (d !== pd && sclk2) viol++;
      if (sclk2 && latch2) viol++;
      if (latch2) begin
        check("div3_rises_per_row", rises, 16);
        rises = 0;
        if (q_lat2.size() == 0) check("div3_latch_unexpected", 1, 0);
        else begin
          le = q_lat2.pop_front();
          check("div3_latch_cycle", cyc, le.cyc);
          check("div3_row_addr", row_addr2, le.addr);
        end
      end
      if (!oe_n2) olow++;
      else if (!po) begin
        check("div3_oe_low_len", olow, 4);
        olow = 0;
      end
      pd = d; ps = sclk2; po = oe_n2;
    end
  end

  initial begin : stim
    int quiet;
    for (int i = 0; i < 16; i++) begin
      pr[i] = 16'h0; pg[i] = 16'h0; pb[i] = 16'h0;
    end
    pr[0] = 16'hA5C3; pg[0] = 16'h3C5A; pb[0] = 16'hF00F;
    pr[6] = 16'h6E91; pg[6] = 16'h0FF0; pb[6] = 16'h8001;
    rst = 1'b1; en = 1'b0; en2 = 1'b0;

    // Test 1: reset state and quiet idle.
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {col_sel, row_sel, row_addr, r_out, g_out, b_out, sclk, latch, oe_n, fd}, 32'h2);
    rst = 1'b0;
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      if (sclk || latch || !oe_n) quiet++;
    end
    check("idle_quiet", quiet, 0);
    check("idle_outputs",
          {col_sel, row_sel, row_addr, r_out, g_out, b_out, sclk, latch, oe_n, fd}, 32'h2);

    // Tests 2/3: first row data and timing, then continuous frames.
    n0 = cyc + 1;
    push_row_data(0, 1'b0);
    push_rows(n0, 34);
    q_fd.push_back(n0 + 624);
    q_fd.push_back(n0 + 1248);
    mon_data = 1;
    en = 1'b1;
    repeat (35) @(negedge clk);
    mon_data = 0;
    repeat (1265) @(negedge clk);
    en = 1'b0;
    repeat (40) @(negedge clk);
    check("t3_row_sel_after_stop", row_sel, 2);
    check("t3_idle_oe", oe_n, 1);

    // Test 4: EN dropped while shifting row 5.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n0 = cyc + 1;
    push_rows(n0, 6);
    en = 1'b1;
    repeat (200) @(negedge clk);
    check("t4_row_sel_mid_shift", row_sel, 5);
    en = 1'b0;
    repeat (40) @(negedge clk);
    check("t4_idle_oe", oe_n, 1);
    check("t4_idle_col_sel", col_sel, 0);
    check("t4_idle_row_sel", row_sel, 6);
    check("t4_row_addr", row_addr, 5);
    n0 = cyc + 1;
    push_row_data(6, 1'b0);
    q_lat.push_back('{6, n0 + 34});
    mon_data = 1;
    en = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b0;
    repeat (45) @(negedge clk);
    mon_data = 0;
    check("t4_resume_row_sel", row_sel, 7);
    check("t4_resume_row_addr", row_addr, 6);

    // Test 5: asynchronous reset during display of row 9.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n0 = cyc + 1;
    push_rows(n0, 10);
    en = 1'b1;
    repeat (387) @(negedge clk);
    check("t5_oe_before_rst", oe_n, 0);
    check("t5_addr_before_rst", row_addr, 9);
    #1 rst = 1'b1;
    rst_pulsed = 1;
    #1;
    check("t5_async_oe", oe_n, 1);
    check("t5_async_row_sel", row_sel, 0);
    check("t5_async_row_addr", row_addr, 0);
    #1 rst = 1'b0;
    n0 = cyc + 1;
    push_row_data(0, 1'b0);
    q_lat.push_back('{0, n0 + 34});
    mon_data = 1;
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (45) @(negedge clk);
    mon_data = 0;
    check("t5_restart_row_sel", row_sel, 1);

    // Test 6: CLK_DIV=3 instance.
    n0 = cyc + 1;
    push_row_data(0, 1'b1);
    q_lat2.push_back('{0, n0 + 98});
    mon_data2 = 1;
    en2 = 1'b1;
    repeat (5) @(negedge clk);
    en2 = 1'b0;
    repeat (120) @(negedge clk);
    mon_data2 = 0;
    check("t6_row_sel", row_sel2, 1);
    check("t6_idle_oe", oe_n2, 1);

    check("left_data",  q_data.size(),  0);
    check("left_latch", q_lat.size(),   0);
    check("left_fd",    q_fd.size(),    0);
    check("left_data2", q_data2.size(), 0);
    check("left_latch2", q_lat2.size(), 0);
    check("invariants", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
